bp_update_sched: RTL and testbench

Scheduler for the update port of `bp_gshare`. It buffers branch resolutions arriving from writeback, then drains them one per cycle onto the predictor's `prev_is_BR` / `prev_BR_alias` / `prev_BR_result` inputs. It gates the predictor's `LD` during front-end stalls and recovery. On a mispredict it runs a fixed-length recovery window that flushes fetch and suspends predictor updates.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_update_sched_if.sv | 34 +++
 rtl/bp_res_fifo.sv | 69 ++++++
 rtl/bp_update_sched.sv | 108 ++++++++++
 tb/tb_bp_update_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_pkg
// Brief  : Shared types for the gshare update scheduler.
// Rev    : 1.0
// ============================================================================
package bp_pkg;

  localparam int BP_ALIAS_W = 6;

  typedef struct packed {
    logic [BP_ALIAS_W-1:0] br_alias;
    logic                  taken;
    logic                  mispred;
  } bp_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } bp_state_e;

  function automatic logic is_mispred(input logic taken, input logic pred);
    return taken ^ pred;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_update_sched_if.sv
`default_nettype none
// ============================================================================
// Module : bp_update_sched_if
// Brief  : Writeback offer, front-end stall and predictor update bundle.
// Rev    : 1.0
// ============================================================================
interface bp_update_sched_if;
  import bp_pkg::*;

  logic                  wb_valid;
  logic [BP_ALIAS_W-1:0] wb_alias;
  logic                  wb_taken;
  logic                  wb_pred;
  logic                  wb_ready;
  logic                  fetch_stall;
  logic                  prev_is_BR;
  logic [BP_ALIAS_W-1:0] prev_BR_alias;
  logic                  prev_BR_result;
  logic                  LD;
  logic                  flush;
  logic                  busy;

  modport master (
    output wb_valid, wb_alias, wb_taken, wb_pred, fetch_stall,
    input  wb_ready, prev_is_BR, prev_BR_alias, prev_BR_result, LD, flush, busy
  );

  modport slave (
    input  wb_valid, wb_alias, wb_taken, wb_pred, fetch_stall,
    output wb_ready, prev_is_BR, prev_BR_alias, prev_BR_result, LD, flush, busy
  );

endinterface
`default_nettype wire

// File: rtl/bp_res_fifo.sv
`default_nettype none
// ============================================================================
// Module : bp_res_fifo
// Brief  : Power-of-two FIFO of branch resolutions with occupancy count.
// Rev    : 1.0
// ============================================================================
module bp_res_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire bp_entry_t                din,
  output logic                          full,
  output logic                          empty,
  output bp_entry_t                     head,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bp_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               w_wr;
  logic               w_rd;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Requests that would overflow or underflow are ignored here.
  assign w_wr = push & ~full;
  assign w_rd = pop  & ~empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_rd) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({w_wr, w_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module : bp_update_sched
// Brief  : Buffers branch resolutions and drains them onto the gshare update port.
// Rev    : 1.0
// ============================================================================
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int RECOV_CYC = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  bp_update_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RC_W  = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;

  bp_state_e         state_q;
  bp_state_e         state_d;
  logic [RC_W-1:0]   rcnt_q;
  logic [RC_W-1:0]   rcnt_d;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  bp_entry_t         w_din;
  bp_entry_t         w_head;
  logic [CNT_W-1:0]  w_count;

  assign w_din = '{br_alias: bus.wb_alias,
                   taken:    bus.wb_taken,
                   mispred:  is_mispred(bus.wb_taken, bus.wb_pred)};

  // Readiness reflects the occupancy before this cycle's dequeue.
  assign w_push = bus.wb_valid & ~w_full;
  assign w_pop  = (state_q == DRAIN) & ~bus.fetch_stall & ~w_empty;

  bp_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      IDLE: begin
        if (!w_empty && !bus.fetch_stall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop) begin
          if (w_head.mispred) begin
            state_d = RECOVER;
            rcnt_d  = RC_W'(RECOV_CYC - 1);
          end else if ((w_count == CNT_W'(1)) && !w_push) begin
            state_d = IDLE;
          end
        end
      end
      RECOVER: begin
        // The window length is fixed; stalls never stretch it.
        if (rcnt_q == '0) begin
          state_d = w_empty ? IDLE : DRAIN;
        end else begin
          rcnt_d = rcnt_q - RC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.wb_ready       = ~w_full;
  assign bus.prev_is_BR     = w_pop;
  assign bus.prev_BR_alias  = w_pop ? w_head.br_alias : '0;
  assign bus.prev_BR_result = w_pop ? w_head.taken    : 1'b0;
  assign bus.LD             = ~bus.fetch_stall & (state_q != RECOVER);
  assign bus.flush          = (state_q == RECOVER);
  assign bus.busy           = ~w_empty | (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_bp_update_sched
// Brief  : Directed plus randomized checks of the update scheduler against a queue model.
// Rev    : 1.0
// ============================================================================
module tb_bp_update_sched;
  import bp_pkg::*;

  localparam int DEPTH     = 4;
  localparam int RECOV_CYC = 2;

  typedef struct {
    logic [5:0] a;
    logic       t;
    logic       m;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  bp_update_sched_if bus ();

  bp_update_sched #(
    .DEPTH     (DEPTH),
    .RECOV_CYC (RECOV_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: pending entries in arrival order, whether updates are being
  // issued, and how many flush cycles remain in the current recovery window.
  ent_t q[$];
  bit   draining;
  int   recov_left;
  int   n_cmp;
  int   n_mis;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] a, input logic t, input logic p,
                      input logic st, output bit acc);
    int   n;
    bit   rdy;
    bit   deq;
    ent_t hd;
    bus.wb_valid    = v;
    bus.wb_alias    = a;
    bus.wb_taken    = t;
    bus.wb_pred     = p;
    bus.fetch_stall = st;
    @(negedge clk);
    n   = q.size();
    rdy = (n != DEPTH);
    deq = draining && (recov_left == 0) && !st && (n > 0);
    hd  = '{a: 6'h0, t: 1'b0, m: 1'b0};
    if (n > 0) hd = q[0];
    chk("wb_ready",       bus.wb_ready,       rdy);
    chk("prev_is_BR",     bus.prev_is_BR,     deq);
    chk("prev_BR_alias",  bus.prev_BR_alias,  deq ? hd.a : 6'h0);
    chk("prev_BR_result", bus.prev_BR_result, deq ? hd.t : 1'b0);
    chk("LD",             bus.LD,             !st && (recov_left == 0));
    chk("flush",          bus.flush,          recov_left > 0);
    chk("busy",           bus.busy,           (n > 0) || draining || (recov_left > 0));
    acc = v && rdy;
    if (recov_left > 0) begin
      recov_left--;
      if (recov_left == 0) draining = (n != 0);
    end else if (!draining) begin
      if (n != 0 && !st) draining = 1'b1;
    end else if (deq) begin
      if (hd.m) begin
        recov_left = RECOV_CYC;
        draining   = 1'b0;
      end else if (n - 1 + int'(acc) == 0) begin
        draining = 1'b0;
      end
    end
    if (deq) void'(q.pop_front());
    if (acc) q.push_back('{a: a, t: t, m: t ^ p});
    @(posedge clk);
    #1;
  endtask

  task automatic rst_step(input logic [5:0] a, input logic st);
    bus.wb_valid    = 1'b1;
    bus.wb_alias    = a;
    bus.wb_taken    = 1'b1;
    bus.wb_pred     = 1'b0;
    bus.fetch_stall = st;
    @(negedge clk);
    chk("rst_wb_ready",   bus.wb_ready,      1'b1);
    chk("rst_prev_is_BR", bus.prev_is_BR,    1'b0);
    chk("rst_alias",      bus.prev_BR_alias, 6'h0);
    chk("rst_flush",      bus.flush,         1'b0);
    chk("rst_busy",       bus.busy,          1'b0);
    chk("rst_LD",         bus.LD,            !st);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    draining   = 1'b0;
    recov_left = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit t;
    n_cmp = 0;
    n_mis = 0;
    model_clear();
    reset           = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_alias    = '0;
    bus.wb_taken    = 1'b0;
    bus.wb_pred     = 1'b0;
    bus.fetch_stall = 1'b0;

    // Reset held with offers present: nothing may be captured.
    for (int i = 0; i < 4; i++) rst_step(6'($urandom), 1'(i % 2));
    reset = 1'b1;
    repeat (2) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);

    // Single correctly predicted branch.
    step(1'b1, 6'h2A, 1'b1, 1'b1, 1'b0, acc);
    repeat (5) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);

    // Fill under stall, then backpressure on the fifth offer.
    for (int a = 1; a <= 4; a++) step(1'b1, 6'(a), 1'(a % 2), 1'(a % 2), 1'b1, acc);
    repeat (3) step(1'b1, 6'd5, 1'b0, 1'b0, 1'b1, acc);
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) step(1'b1, 6'd5, 1'b0, 1'b0, 1'b0, acc);
    repeat (8) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);

    // Mispredict followed by a clean entry.
    step(1'b1, 6'd7, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 6'd8, 1'b1, 1'b1, 1'b0, acc);
    repeat (8) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);

    // Back-to-back stream that wraps the pointers.
    for (int i = 0; i < 10; i++) begin
      t = 1'($urandom);
      step(1'b1, 6'(10 + i), t, t, 1'b0, acc);
    end
    repeat (8) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);

    // Reset asserted inside the recovery window with entries pending.
    step(1'b1, 6'd20, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 6'd21, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 6'd22, 1'b1, 1'b1, 1'b0, acc);
    for (int k = 0; k < 6 && recov_left == 0; k++) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);
    bus.wb_valid = 1'b0;
    reset        = 1'b0;
    #1;
    chk("midrec_flush",      bus.flush,      1'b0);
    chk("midrec_busy",       bus.busy,       1'b0);
    chk("midrec_prev_is_BR", bus.prev_is_BR, 1'b0);
    chk("midrec_wb_ready",   bus.wb_ready,   1'b1);
    model_clear();
    repeat (2) rst_step(6'h3F, 1'b0);
    reset = 1'b1;
    repeat (6) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);

    // Randomized traffic with stalls and roughly one mispredict in four.
    for (int i = 0; i < 400; i++) begin
      logic v, p, st;
      logic [5:0] a;
      v  = 1'($urandom_range(0, 1));
      a  = 6'($urandom);
      t  = 1'($urandom);
      p  = ($urandom_range(0, 3) == 0) ? ~t : t;
      st = ($urandom_range(0, 3) == 0);
      step(v, a, t, p, st, acc);
    end
    repeat (40) step(1'b0, 6'h0, 1'b0, 1'b0, 1'b0, acc);
    chk("final_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
